r5fp_unpack_pipe: RTL and testbench

R5FP_UNPACK_PIPE -- requirements
Module: R5FP_unpack_pipe

---
 rtl/r5fp_unpack_pipe_if.sv | 32 +++
 rtl/r5fp_unpack_pipe.sv | 151 +++++++++++++++
 tb/tb_r5fp_unpack_pipe.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/r5fp_unpack_pipe_if.sv
// Handshake and data bundle for the IEEE operand unpack pipeline.
// The master side feeds operands and drains results; the slave side is the pipeline.
interface r5fp_unpack_pipe_if #(
  parameter int EXP_W = 11,
  parameter int SIG_W = 52,
  parameter int TAG_W = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [EXP_W+SIG_W:0]   a;
  logic [2:0]             rnd;
  logic [TAG_W-1:0]       tag_in;

  logic                   out_valid;
  logic                   out_ready;
  logic                   zSign;
  logic [EXP_W:0]         zExp;
  logic [SIG_W:0]         zSig;
  logic [5:0]             zStatus;
  logic [2:0]             rnd_out;
  logic [TAG_W-1:0]       tag_out;

  modport master (
    output in_valid, a, rnd, tag_in, out_ready,
    input  in_ready, out_valid, zSign, zExp, zSig, zStatus, rnd_out, tag_out
  );

  modport slave (
    input  in_valid, a, rnd, tag_in, out_ready,
    output in_ready, out_valid, zSign, zExp, zSig, zStatus, rnd_out, tag_out
  );
endinterface

// File: rtl/r5fp_unpack_pipe.sv
// Two-stage IEEE operand unpacker: S1 classifies and counts leading zeros,
// S2 normalizes subnormals and registers the unpacked result.
module r5fp_unpack_pipe #(
  parameter int EXP_W = 11,
  parameter int SIG_W = 52,
  parameter int TAG_W = 4
) (
  input logic               clk,
  input logic               rst_n,
  r5fp_unpack_pipe_if.slave bus
);

  localparam int LZ_W = $clog2(SIG_W + 1);
  localparam int ZE_W = EXP_W + 1;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] frac;
    logic             isZero;
    logic             isInf;
    logic             isQnan;
    logic             isSnan;
    logic             isSub;
    logic [LZ_W-1:0]  lz;
    logic [2:0]       rnd;
    logic [TAG_W-1:0] tag;
  } s1_t;

  logic s1Valid, s2Valid;
  logic s1Adv, s2Adv;
  s1_t  s1D, s1Q;

  // Each stage moves when its successor has room; a full pipe still accepts
  // while the output drains.
  assign s2Adv        = !s2Valid || bus.out_ready;
  assign s1Adv        = !s1Valid || s2Adv;
  assign bus.in_ready = rst_n && s1Adv;

  // ---------------- S1: classify + leading-zero count ----------------
  logic [EXP_W-1:0] inExp;
  logic [SIG_W-1:0] inFrac;
  logic             expZero, expOnes, fracZero;
  logic [LZ_W-1:0]  lzCnt;

  assign inExp    = bus.a[EXP_W+SIG_W-1:SIG_W];
  assign inFrac   = bus.a[SIG_W-1:0];
  assign expZero  = (inExp == '0);
  assign expOnes  = (inExp == '1);
  assign fracZero = (inFrac == '0);

  // NOTE: every always_comb output gets a default before any conditional
  // write, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    lzCnt = LZ_W'(SIG_W);
    for (int i = 0; i < SIG_W; i++) begin
      if (inFrac[i]) lzCnt = LZ_W'(SIG_W - 1 - i);
    end
  end

  always_comb begin
    s1D.sign   = bus.a[EXP_W+SIG_W];
    s1D.exp    = inExp;
    s1D.frac   = inFrac;
    s1D.isZero = expZero && fracZero;
    s1D.isSub  = expZero && !fracZero;
    s1D.isInf  = expOnes && fracZero;
    s1D.isQnan = expOnes && !fracZero && inFrac[SIG_W-1];
    s1D.isSnan = expOnes && !fracZero && !inFrac[SIG_W-1];
    s1D.lz     = lzCnt;
    s1D.rnd    = bus.rnd;
    s1D.tag    = bus.tag_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid <= 1'b0;
      s1Q     <= '0;
    end else if (s1Adv) begin
      s1Valid <= bus.in_valid;
      if (bus.in_valid) s1Q <= s1D;
    end
  end

  // ---------------- S2: normalize + output registers ----------------
  logic [LZ_W:0]    shAmt;
  logic [SIG_W:0]   subSig;
  logic [ZE_W-1:0]  subExp;
  logic [ZE_W-1:0]  zExpD;
  logic [SIG_W:0]   zSigD;
  logic [5:0]       zStatusD;

  assign shAmt  = {1'b0, s1Q.lz} + 1'b1;
  assign subSig = {1'b0, s1Q.frac} << shAmt;
  assign subExp = ZE_W'(1) - ZE_W'(shAmt);

  // Normal, Inf and NaN all share {exp, 1.frac}; an all-ones exponent with a
  // zero fraction already yields the Inf encoding.
  always_comb begin
    zExpD    = {1'b0, s1Q.exp};
    zSigD    = {1'b1, s1Q.frac};
    zStatusD = {1'b0, s1Q.isSub, s1Q.isSnan, s1Q.isQnan, s1Q.isInf, s1Q.isZero};
    if (s1Q.isZero) begin
      zExpD = '0;
      zSigD = '0;
    end else if (s1Q.isSub) begin
      zExpD = subExp;
      zSigD = subSig;
    end
  end

  logic             zSignQ;
  logic [ZE_W-1:0]  zExpQ;
  logic [SIG_W:0]   zSigQ;
  logic [5:0]       zStatusQ;
  logic [2:0]       rndQ;
  logic [TAG_W-1:0] tagQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2Valid  <= 1'b0;
      zSignQ   <= 1'b0;
      zExpQ    <= '0;
      zSigQ    <= '0;
      zStatusQ <= '0;
      rndQ     <= '0;
      tagQ     <= '0;
    end else if (s2Adv) begin
      s2Valid <= s1Valid;
      if (s1Valid) begin
        zSignQ   <= s1Q.sign;
        zExpQ    <= zExpD;
        zSigQ    <= zSigD;
        zStatusQ <= zStatusD;
        rndQ     <= s1Q.rnd;
        tagQ     <= s1Q.tag;
      end
    end
  end

  assign bus.out_valid = s2Valid;
  assign bus.zSign     = zSignQ;
  assign bus.zExp      = zExpQ;
  assign bus.zSig      = zSigQ;
  assign bus.zStatus   = zStatusQ;
  assign bus.rnd_out   = rndQ;
  assign bus.tag_out   = tagQ;

endmodule

// File: tb/tb_r5fp_unpack_pipe.sv
// Directed + random bench for r5fp_unpack_pipe with a result scoreboard
// and an output-hold monitor.
module tb_r5fp_unpack_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  r5fp_unpack_pipe_if #(.EXP_W(11), .SIG_W(52), .TAG_W(4)) bus ();

  r5fp_unpack_pipe #(.EXP_W(11), .SIG_W(52), .TAG_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic        sign;
    logic [11:0] exp;
    logic [52:0] sig;
    logic [5:0]  st;
    logic [2:0]  rnd;
    logic [3:0]  tag;
  } res_t;

  res_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, expv);
    end
  endtask

  function automatic res_t mk(input logic s, input logic [11:0] e, input logic [52:0] g,
                              input logic [5:0] st, input logic [2:0] r, input logic [3:0] t);
    res_t x;
    x.sign = s; x.exp = e; x.sig = g; x.st = st; x.rnd = r; x.tag = t;
    return x;
  endfunction

  // Reference: walk a subnormal left one bit at a time until the hidden bit appears.
  function automatic res_t model(input logic [63:0] av, input logic [2:0] r, input logic [3:0] t);
    logic [10:0] e;
    logic [51:0] f;
    logic [52:0] g;
    logic [11:0] ex;
    e = av[62:52];
    f = av[51:0];
    if (e == 11'd0 && f == 52'd0) return mk(av[63], 12'd0, 53'd0, 6'h01, r, t);
    if (e == 11'd0) begin
      g  = {1'b0, f};
      ex = 12'd1;
      while (!g[52]) begin
        g  = g << 1;
        ex = ex - 12'd1;
      end
      return mk(av[63], ex, g, 6'h10, r, t);
    end
    if (e == 11'h7FF) begin
      if (f == 52'd0) return mk(av[63], 12'd2047, {1'b1, 52'd0}, 6'h02, r, t);
      return mk(av[63], 12'd2047, {1'b1, f}, f[51] ? 6'h04 : 6'h08, r, t);
    end
    return mk(av[63], {1'b0, e}, {1'b1, f}, 6'h00, r, t);
  endfunction

  function automatic logic [63:0] randA();
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 4))
      0: begin v[62:52] = 11'd0; v[51:0] = v[51:0] >> $urandom_range(0, 52); end
      1: v[62:52] = 11'h7FF;
      2: begin v[62:52] = 11'h7FF; v[51:0] = 52'd0; end
      default: v[62:52] = 11'(1 + $urandom_range(0, 2045));
    endcase
    return v;
  endfunction

  function automatic logic [78:0] outVec();
    return {bus.zSign, bus.zExp, bus.zSig, bus.zStatus, bus.rnd_out, bus.tag_out};
  endfunction

  // Scoreboard drain and hold-while-stalled monitor.
  logic        stalled = 1'b0;
  logic [79:0] snap;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) check("hold_stable", {bus.out_valid, outVec()}, snap);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) check("unexpected_out", bus.out_valid, 1'b0);
        else check("result", outVec(), sb.pop_front());
        stalled = 1'b0;
      end else if (bus.out_valid) begin
        stalled = 1'b1;
        snap    = {bus.out_valid, outVec()};
      end else begin
        stalled = 1'b0;
      end
    end
  end

  task automatic sendOp(input logic [63:0] av, input logic [2:0] r, input logic [3:0] t, input res_t e);
    bit done = 1'b0;
    bus.in_valid = 1'b1; bus.a = av; bus.rnd = r; bus.tag_in = t;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) check("send_timeout", bus.in_ready, 1'b1);
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
    @(posedge clk); #1;
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    logic [63:0] ra;
    logic [2:0]  rr;
    logic [3:0]  rt;
    int          sent;

    bus.in_valid = 1'b0; bus.a = '0; bus.rnd = '0; bus.tag_in = '0; bus.out_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_outputs", outVec(), 79'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;

    // Latency: accepted in cycle 0, visible in cycle 2.
    sendOp(64'h3FF0000000000000, 3'd2, 4'd7, mk(1'b0, 12'd1023, 53'h10000000000000, 6'h00, 3'd2, 4'd7));
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1", bus.out_valid, 1'b0);
    @(negedge clk);
    check("lat_cycle2", bus.out_valid, 1'b1);
    @(posedge clk); #1;

    // Class vectors back to back.
    sendOp(64'h0000000000000001, 3'd1, 4'd1, mk(1'b0, 12'hFCD, 53'h10000000000000, 6'h10, 3'd1, 4'd1));
    sendOp(64'hFFF0000000000000, 3'd3, 4'd2, mk(1'b1, 12'd2047, 53'h10000000000000, 6'h02, 3'd3, 4'd2));
    sendOp(64'h7FF0000000000001, 3'd4, 4'd3, mk(1'b0, 12'd2047, 53'h10000000000001, 6'h08, 3'd4, 4'd3));
    sendOp(64'h7FF8000000000000, 3'd5, 4'd4, mk(1'b0, 12'd2047, 53'h18000000000000, 6'h04, 3'd5, 4'd4));
    sendOp(64'h8000000000000000, 3'd6, 4'd5, mk(1'b1, 12'd0, 53'd0, 6'h01, 3'd6, 4'd5));
    sendOp(64'h0008000000000000, 3'd0, 4'd6, mk(1'b0, 12'd0, 53'h10000000000000, 6'h10, 3'd0, 4'd6));
    sendOp(64'h800FFFFFFFFFFFFF, 3'd7, 4'd8, mk(1'b1, 12'd0, 53'h1FFFFFFFFFFFFE, 6'h10, 3'd7, 4'd8));
    sendOp(64'h7FEFFFFFFFFFFFFF, 3'd1, 4'd9, mk(1'b0, 12'd2046, 53'h1FFFFFFFFFFFFF, 6'h00, 3'd1, 4'd9));
    sendOp(64'hC000000000000123, 3'd2, 4'hA, model(64'hC000000000000123, 3'd2, 4'hA));
    drain();

    // Five operands with out_ready low for cycles 3..6.
    sent = 0;
    for (int c = 0; c < 20; c++) begin
      bus.out_ready = !(c >= 3 && c <= 6);
      if (sent < 5) begin
        bus.in_valid = 1'b1;
        bus.a        = 64'h4000000000000000 + 64'(sent * 64'h0001000000000011);
        bus.rnd      = 3'(sent);
        bus.tag_in   = 4'(sent + 1);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (c >= 3 && c <= 6) begin
        check("stall_in_ready", bus.in_ready, 1'b0);
        check("stall_out_valid", bus.out_valid, 1'b1);
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(model(bus.a, bus.rnd, bus.tag_in));
        sent++;
      end
      @(posedge clk); #1;
    end
    check("stall_sent", sent, 5);
    drain();

    // Random valid/ready traffic across all classes.
    sent = 0;
    ra = randA(); rr = 3'($urandom); rt = 4'($urandom);
    for (int c = 0; c < 600 && sent < 40; c++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.a = ra; bus.rnd = rr; bus.tag_in = rt;
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(model(ra, rr, rt));
        sent++;
        ra = randA(); rr = 3'($urandom); rt = 4'($urandom);
      end
      @(posedge clk); #1;
    end
    check("rand_sent", sent, 40);
    drain();

    // Reset with two operands in flight.
    sendOp(64'h3FF8000000000000, 3'd1, 4'hB, model(64'h3FF8000000000000, 3'd1, 4'hB));
    sendOp(64'hBFF0000000000000, 3'd2, 4'hC, model(64'hBFF0000000000000, 3'd2, 4'hC));
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_outputs", outVec(), 79'd0);
    check("midrst_in_ready", bus.in_ready, 1'b0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_midrst_idle", bus.out_valid, 1'b0);
      if (c == 0) check("post_midrst_in_ready", bus.in_ready, 1'b1);
    end
    @(posedge clk); #1;
    sendOp(64'h0000000000000003, 3'd3, 4'hD, mk(1'b0, 12'hFCE, 53'h18000000000000, 6'h10, 3'd3, 4'hD));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
